// File: rtl/normalizer_pkg.sv
// Shared definitions for the N-lane spectrum normaliser: FSM state encoding,
// the default lane width and a lane slicing helper for packed lane buses.
package normalizer_pkg;

  localparam int DEFAULT_DW = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    WAIT_SQRT = 2'd2,
    OUTPUT    = 2'd3
  } state_t;

  // Bit offset of lane 'lane' inside a packed bus of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/normalizer_lane_post.sv
// Per-lane result formatting: picks the sqrt root or the scaled magnitude with
// its sign restored. With NORMALIZER_LANES_CLAMP_EN defined, the scaled
// magnitude is saturated to [min_lim, max_lim] before the sign is applied.
module normalizer_lane_post
  import normalizer_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [2*DW-1:0] i_prod,
  input  logic [DW-1:0]   i_root,
  input  logic            i_minus,
  input  logic            i_sqrt_mode,
`ifdef NORMALIZER_LANES_CLAMP_EN
  input  logic [DW-1:0]   i_min_lim,
  input  logic [DW-1:0]   i_max_lim,
`endif
  output logic [DW-1:0]   o_result
);

  logic [DW-1:0] w_mag;
  logic [DW-1:0] w_sat;
  logic          w_unused_prod_lo;

  // The fractional half of the product is discarded by the scaling.
  assign w_mag            = i_prod[2*DW-1:DW];
  assign w_unused_prod_lo = ^i_prod[DW-1:0];

`ifdef NORMALIZER_LANES_CLAMP_EN
  // Low bound first, then high bound, so an inverted window resolves to max_lim.
  always_comb begin
    w_sat = w_mag;
    if (w_mag < i_min_lim) w_sat = i_min_lim;
    if (w_sat > i_max_lim) w_sat = i_max_lim;
  end
`else
  assign w_sat = w_mag;
`endif

  // Select root in sqrt mode, otherwise two's-complement the magnitude when negative.
  always_comb begin
    o_result = w_sat;
    if (i_sqrt_mode)  o_result = i_root;
    else if (i_minus) o_result = (~w_sat) + DW'(1);
  end

endmodule

// File: rtl/normalizer_lanes.sv
// N-lane spectrum normaliser: per accepted word either scales each lane by
// max_value (keeping the upper product half, sign restored) or hands each
// lane to an external sqrt core and collects the roots independently.
// Optional macro NORMALIZER_LANES_CLAMP_EN enables scale-mode saturation.
module normalizer_lanes
  import normalizer_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int DW           = DEFAULT_DW,
  parameter int LANE_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sqrt_normal,
  input  logic [DW-1:0]         max_value,
  input  logic [DW-1:0]         min_lim,
  input  logic [DW-1:0]         max_lim,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES-1:0]      in_minus,
  input  logic                  in_valid,
  output logic                  in_rdy,
  output logic [LANES*2*DW-1:0] sqrt_rad,
  output logic [LANES-1:0]      sqrt_start,
  input  logic [LANES-1:0]      sqrt_valid,
  input  logic [LANES*2*DW-1:0] sqrt_root,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_rdy
);

  state_t              r_state;
  logic [DW-1:0]       r_data [LANES];
  logic [LANES-1:0]    r_minus;
  logic [2*DW-1:0]     r_prod [LANES];
  logic [DW-1:0]       r_root [LANES];
  logic [LANES-1:0]    r_done_mask;
  logic                r_sqrt_mode;

  logic [LANES-1:0]    w_done_next;
  logic [DW-1:0]       w_root_in  [LANES];
  logic [DW-1:0]       w_lane_res [LANES];
  logic [LANES*DW-1:0] w_root_hi;
  logic                w_calc_sqrt;
  logic                w_unused_inputs;

  // Handshake and sqrt kick-off are decoded from the registered state; start
  // and rst suppress both in the cycle they are asserted.
  assign in_rdy      = (r_state == IDLE) & in_valid & ~start & ~rst;
  assign w_calc_sqrt = (r_state == CALC) & sqrt_normal & ~start & ~rst;
  assign sqrt_start  = {LANES{w_calc_sqrt}};
  assign out_valid   = (r_state == OUTPUT);
  assign w_done_next = r_done_mask | sqrt_valid;

`ifdef NORMALIZER_LANES_CLAMP_EN
  assign w_unused_inputs = ^w_root_hi;
`else
  assign w_unused_inputs = ^{w_root_hi, min_lim, max_lim};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int SRC = (LANE_REVERSE != 0) ? (LANES - 1 - gi) : gi;

      assign sqrt_rad[lane_lsb(gi, 2*DW) +: 2*DW] =
        w_calc_sqrt ? {{DW{1'b0}}, r_data[gi]} : '0;
      assign w_root_in[gi] = sqrt_root[lane_lsb(gi, 2*DW) +: DW];
      assign w_root_hi[lane_lsb(gi, DW) +: DW] = sqrt_root[lane_lsb(gi, 2*DW) + DW +: DW];

      normalizer_lane_post #(.DW(DW)) u_post (
        .i_prod      (r_prod[gi]),
        .i_root      (r_root[gi]),
        .i_minus     (r_minus[gi]),
        .i_sqrt_mode (r_sqrt_mode),
`ifdef NORMALIZER_LANES_CLAMP_EN
        .i_min_lim   (min_lim),
        .i_max_lim   (max_lim),
`endif
        .o_result    (w_lane_res[gi])
      );

      // Output word is zero outside OUTPUT so idle/reset outputs read as 0.
      assign out_data[lane_lsb(gi, DW) +: DW] = out_valid ? w_lane_res[SRC] : '0;
    end
  endgenerate

  // Control FSM with per-lane datapath registers; rst/start clear everything.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_state     <= IDLE;
      r_minus     <= '0;
      r_done_mask <= '0;
      r_sqrt_mode <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_data[i] <= '0;
        r_prod[i] <= '0;
        r_root[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (in_rdy) begin
            for (int i = 0; i < LANES; i++) r_data[i] <= in_data[lane_lsb(i, DW) +: DW];
            r_minus <= in_minus;
            r_state <= CALC;
          end
        end
        CALC: begin
          for (int i = 0; i < LANES; i++)
            r_prod[i] <= (2*DW)'(max_value) * (2*DW)'(r_data[i]);
          r_sqrt_mode <= sqrt_normal;
          r_done_mask <= '0;
          r_state     <= sqrt_normal ? WAIT_SQRT : OUTPUT;
        end
        WAIT_SQRT: begin
          for (int i = 0; i < LANES; i++)
            if (sqrt_valid[i] && !r_done_mask[i]) r_root[i] <= w_root_in[i];
          r_done_mask <= w_done_next;
          if (&w_done_next) r_state <= OUTPUT;
        end
        OUTPUT: begin
          if (out_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/normalizer_lanes.md
Name: normalizer_lanes

Overview:
- N-lane successor of the two-lane spectrum normaliser; sits between the spectrum scaler and the feature/classifier stage.
- Per frame word, either scales each lane by `max_value` and restores its sign, or takes an integer square root of each lane through external per-lane sqrt cores.
- Data width, lane count and output lane order are parametrised.
- Sqrt lanes may complete on different cycles; the block collects them independently.

Parameters:
- LANES, 2, number of parallel lanes (1..8).
- DW, 16, lane data width; the multiply product is 2*DW.
- LANE_REVERSE, 1, 1 = output lane i carries input lane LANES-1-i; 0 = identity order.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame-start soft clear.
- sqrt_normal  in  1  mode select: 1 = sqrt, 0 = scale; sampled in CALC.
- max_value  in  DW  unsigned scale factor.
- min_lim  in  DW  clamp low bound (optional feature only).
- max_lim  in  DW  clamp high bound (optional feature only).
- in_data  in  LANES*DW  packed magnitudes; lane i = [i*DW +: DW].
- in_minus  in  LANES  per-lane sign flags.
- in_valid  in  1  input word valid.
- in_rdy  out  1  input accepted this cycle.
- sqrt_rad  out  LANES*2*DW  radicand per lane.
- sqrt_start  out  LANES  one-cycle start pulse per lane.
- sqrt_valid  in  LANES  per-lane result valid.
- sqrt_root  in  LANES*2*DW  per-lane root.
- out_data  out  LANES*DW  result word.
- out_valid  out  1  result valid.
- out_rdy  in  1  downstream ready.

Behaviour:
- Reset: all outputs are 0; internal registers are cleared; state = IDLE.
- Outputs are decoded from registered state, so no output depends combinationally on another output.
- FSM states: IDLE, CALC, WAIT_SQRT, OUTPUT.
- IDLE:
  - `in_rdy = in_valid & ~start`.
  - On accept, latch `in_data` and `in_minus`, then go to CALC.
- CALC (exactly 1 cycle):
  - Register `prod[i] = max_value * data[i]`, an unsigned 2*DW product.
  - If `sqrt_normal`: pulse `sqrt_start` on all lanes, drive `sqrt_rad[i] = zero-extend(data[i])`, clear `done_mask`, go to WAIT_SQRT.
  - Otherwise go to OUTPUT.
  - `sqrt_normal` is latched here for use in OUTPUT.
- WAIT_SQRT:
  - For each lane with `sqrt_valid[i]` high and not yet done, latch `root[i] = sqrt_root[i][DW-1:0]` and set `done_mask[i]`.
  - Extra valids on a lane that is already done are ignored.
  - Go to OUTPUT on the cycle `done_mask` becomes all-ones; this includes all lanes arriving in the same cycle.
  - No timeout.
- OUTPUT:
  - `out_valid = 1`.
  - Sqrt mode: lane value = `root[i]`; the sign is ignored.
  - Scale mode: `mag = prod[i][2*DW-1:DW]`; lane value = `minus ? (~mag + 1) : mag` (two's complement, mod 2^DW).
  - Lane order follows LANE_REVERSE.
  - `out_data` and `out_valid` are held stable until `out_rdy`; then go to IDLE.
- Latency:
  - Scale mode: accept at cycle t, `out_valid` from t+2.
  - Sqrt mode: `out_valid` one cycle after the last lane's valid.
  - With `out_rdy` held high, the throughput is one word per 3 cycles in scale mode.
- start:
  - Highest priority in every state.
  - Next state = IDLE; clears data, minus, root, `done_mask` and results.
  - No `in_rdy` and no `sqrt_start` in that cycle.
  - A pending output word is dropped.
  - Sqrt valids arriving after a start are ignored because the state is IDLE.
- `rst` mid-operation has the same effect as start, plus all outputs go to 0 on the next cycle.
- Edge values:
  - `max_value = 0` gives 0 for both signs (since -0 = 0).
  - A negative lane with `mag = 0` outputs 0.

Optional Feature:
- Macro: NORMALIZER_LANES_CLAMP_EN.
- Defined: in scale mode, `mag` is saturated to [`min_lim`, `max_lim`] before sign restoration. `min_lim > max_lim` resolves to `max_lim`. Sqrt mode is unaffected.
- Undefined: `min_lim` and `max_lim` are unused and no comparators are synthesised.

Decomposition:
- Shared package normalizer_pkg:
  - State enum: IDLE=0, CALC=1, WAIT_SQRT=2, OUTPUT=3.
  - Lane slicing helper function.
  - Default DW constant.
- One natural sub-module, normalizer_lane_post: takes one lane's product, root, minus flag, mode and limits, and outputs the lane result (combinational). It is instantiated LANES times in a generate loop.

Test Plan:
- Scale, LANES=2, `max_value` 0x8000, lane0 = {0x1234, +}, lane1 = {0x1234, −}, LANE_REVERSE=1 → `out_data` = {lane1: 0x091A, lane0: 0xF6E6}, `out_valid` at accept+2.
- Sqrt, `root[0]` valid 1 cycle after start and `root[1]` valid 5 cycles after start, data 0x0400 and 0x0019, external roots 32 and 5 → `out_valid` exactly 1 cycle after lane1 valid; values 0x0020 and 0x0005 in the parametrised order.
- Backpressure: `out_rdy` low for 10 cycles in OUTPUT → `out_data` stable and `in_rdy` = 0 throughout; `out_rdy` pulse → IDLE next cycle.
- start during WAIT_SQRT with one lane done → IDLE next cycle; a later stray `sqrt_valid` produces no `out_valid`; the next word is processed normally.
- Reset (`rst`) asserted in OUTPUT with `out_valid` high → all outputs 0 on the next cycle; in_valid held high during `rst` is not accepted.
- CLAMP_EN, `max_lim` 0x0800, `mag` 0x091A, minus=1 → 0xF800; `min_lim` 0x0100, `mag` 0x0010 → 0x0100.
